// File: rtl/moving_average3_inverse_if.sv
// Sample bus between the moving-sum filter output and the inverse filter.
interface moving_average3_inverse_if #(
    parameter int unsigned WIDTH = 8
);
    logic signed [WIDTH-1:0] eta_i1;
    logic                    eta_valid_i1;
    logic                    clear_i;
    logic signed [WIDTH-1:0] y_o;
    logic                    y_valid_o;
    logic                    primed_o;

    modport master (
        output eta_i1, eta_valid_i1, clear_i,
        input  y_o, y_valid_o, primed_o
    );

    modport slave (
        input  eta_i1, eta_valid_i1, clear_i,
        output y_o, y_valid_o, primed_o
    );
endinterface

// File: rtl/moving_average3_inverse.sv
// Inverse of a TAPS-long moving-sum filter: x[n] = y[n] - y[n-1] + x[n-TAPS], wrapping.
module moving_average3_inverse #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAPS  = 4
) (
    input  logic                      system1000,
    input  logic                      system1000_rst,
    moving_average3_inverse_if.slave  bus
);
    localparam int unsigned CW = $clog2(TAPS + 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic signed [WIDTH-1:0] r_y_prev;
    logic signed [WIDTH-1:0] r_hist [TAPS];
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           w_count_next;
    logic signed [WIDTH-1:0] r_y;
    logic                    r_y_valid;
    logic                    r_primed;
    logic                    w_accept;
    logic signed [WIDTH-1:0] w_x;

    // Accept qualifier and recovered sample (carries out of WIDTH are discarded).
    always_comb begin
        w_accept = bus.eta_valid_i1 & ~bus.clear_i;
        w_x      = WIDTH'(bus.eta_i1 - r_y_prev + r_hist[TAPS-1]);
    end

    // Saturating fill counter and FILL/RUN next-state.
    always_comb begin
        w_count_next = r_count;
        w_state_next = r_state;
        if (bus.clear_i) begin
            w_count_next = '0;
            w_state_next = FILL;
        end else if (w_accept) begin
            if (r_count != CW'(TAPS)) begin
                w_count_next = r_count + CW'(1);
            end
            case (r_state)
                FILL: if (r_count == CW'(TAPS - 1)) w_state_next = RUN;
                RUN:  w_state_next = RUN;
                default: w_state_next = FILL;
            endcase
        end
    end

    // State register; reset and clear both return everything to zero history.
    always_ff @(posedge system1000) begin
        if (system1000_rst || bus.clear_i) begin
            r_state   <= FILL;
            r_y_prev  <= '0;
            r_count   <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_primed  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_hist[k] <= '0;
            end
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_y_valid <= w_accept;
            r_primed  <= (w_state_next == RUN);
            if (w_accept) begin
                r_y       <= w_x;
                r_y_prev  <= bus.eta_i1;
                r_hist[0] <= w_x;
                for (int k = 1; k < TAPS; k++) begin
                    r_hist[k] <= r_hist[k-1];
                end
            end
        end
    end

    assign bus.y_o       = r_y;
    assign bus.y_valid_o = r_y_valid;
    assign bus.primed_o  = r_primed;
endmodule

// File: tb/tb_moving_average3_inverse.sv
// Directed and round-trip checks for moving_average3_inverse.
module tb_moving_average3_inverse;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    moving_average3_inverse_if #(.WIDTH(8)) bus ();

    moving_average3_inverse #(.WIDTH(8), .TAPS(4)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic step(input logic r, input int eta, input logic v, input logic c);
        rst              = r;
        bus.eta_i1       = 8'(eta);
        bus.eta_valid_i1 = v;
        bus.clear_i      = c;
        @(posedge clk);
        #1;
        rst              = 1'b0;
        bus.eta_valid_i1 = 1'b0;
        bus.clear_i      = 1'b0;
    endtask

    int imp_in  [6] = '{5, 5, 5, 5, 0, 0};
    int imp_out [6] = '{5, 0, 0, 0, 0, 0};
    int wrp_in  [5] = '{127, -2, 125, -4, -3};
    int wrp_out [5] = '{127, 127, 127, 127, -128};

    initial begin
        logic signed [7:0] raw;
        logic signed [7:0] sum;
        logic signed [7:0] enc [3];
        int                nacc;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.eta_i1 = '0;
        bus.eta_valid_i1 = 1'b0;
        bus.clear_i = 1'b0;
        #2;
        step(1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 0, 1'b0, 1'b0);
        chk("rst_y", int'(bus.y_o), 0);
        chk("rst_valid", int'(bus.y_valid_o), 0);
        chk("rst_primed", int'(bus.primed_o), 0);

        // Impulse
        for (int i = 0; i < 6; i++) begin
            step(1'b0, imp_in[i], 1'b1, 1'b0);
            chk("imp_y", int'(bus.y_o), imp_out[i]);
            chk("imp_valid", int'(bus.y_valid_o), 1);
            chk("imp_primed", int'(bus.primed_o), (i >= 3) ? 1 : 0);
        end

        // Wrap-around
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, wrp_in[i], 1'b1, 1'b0);
            chk("wrap_y", int'(bus.y_o), wrp_out[i]);
        end

        // Impulse with idle gaps
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, imp_in[i], 1'b1, 1'b0);
            chk("gap_y", int'(bus.y_o), imp_out[i]);
            chk("gap_valid", int'(bus.y_valid_o), 1);
            for (int g = 0; g < (i % 4); g++) begin
                step(1'b0, 99, 1'b0, 1'b0);
                chk("gap_idle_valid", int'(bus.y_valid_o), 0);
                chk("gap_hold_y", int'(bus.y_o), imp_out[i]);
            end
        end
        chk("gap_primed", int'(bus.primed_o), 1);

        // Clear mid-stream drops the coincident sample
        step(1'b0, 9, 1'b1, 1'b1);
        chk("clr_y", int'(bus.y_o), 0);
        chk("clr_valid", int'(bus.y_valid_o), 0);
        chk("clr_primed", int'(bus.primed_o), 0);
        step(1'b0, 3, 1'b1, 1'b0);
        chk("clr_y0", int'(bus.y_o), 3);
        step(1'b0, 3, 1'b1, 1'b0);
        chk("clr_y1", int'(bus.y_o), 0);

        // Reset priority over valid and clear
        step(1'b0, 50, 1'b1, 1'b0);
        step(1'b0, 60, 1'b1, 1'b0);
        chk("pre_rst_primed", int'(bus.primed_o), 1);
        step(1'b1, 7, 1'b1, 1'b1);
        chk("prio_y", int'(bus.y_o), 0);
        chk("prio_valid", int'(bus.y_valid_o), 0);
        chk("prio_primed", int'(bus.primed_o), 0);
        step(1'b0, 2, 1'b1, 1'b0);
        chk("post_rst_y", int'(bus.y_o), 2);
        chk("post_rst_primed", int'(bus.primed_o), 0);

        // Random round trip through a reference moving-sum encoder
        step(1'b0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) enc[k] = '0;
        nacc = 0;
        for (int i = 0; i < 1000; i++) begin
            raw = 8'($urandom_range(255));
            sum = 8'(raw + enc[0] + enc[1] + enc[2]);
            enc[2] = enc[1];
            enc[1] = enc[0];
            enc[0] = raw;
            step(1'b0, int'(sum), 1'b1, 1'b0);
            nacc++;
            chk("rt_y", int'(bus.y_o), int'(raw));
            if (nacc <= 4) chk("rt_primed", int'(bus.primed_o), (nacc == 4) ? 1 : 0);
            for (int g = 0; g < int'($urandom_range(2)); g++) begin
                step(1'b0, int'($urandom_range(255)), 1'b0, 1'b0);
                chk("rt_idle_valid", int'(bus.y_valid_o), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
